// File: rtl/uart_receiver.sv
// 8N1 UART receiver with start-bit validation, mid-bit sampling and a receive FIFO.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 majority vote on every sample.
module uart_receiver #(
  parameter int CLK_FREQ   = 48000000,
  parameter int BAUDRATE   = 250000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_read,
  output logic       framing_error,
  output logic       overflow
);

  localparam int CLK_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int HALF_BIT    = CLK_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST  = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r;
  logic [15:0]   cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    shift_r;
  logic          framing_error_r;
  logic          overflow_r;
  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_prev_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [7:0]    mem_r [FIFO_DEPTH];

  logic sample_s;
  logic stop_hit_s;
  logic push_s;
  logic pop_s;
  logic full_s;
  logic empty_s;
  logic accept_s;

  // Two-flop synchroniser; rx_prev_r remembers the previous synchronised level for edge arming
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_r;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Two previous synchronised samples, combined with the current one for the vote
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], rx_sync_r};
    end
  end

  assign sample_s = maj3(rx_sync_r, hist_r[0], hist_r[1]);
`else
  assign sample_s = rx_sync_r;
`endif

  // Frame FSM: start validation, LSB-first data shifting, stop check
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      cnt_r           <= 16'd0;
      idx_r           <= 3'd0;
      shift_r         <= 8'h00;
      framing_error_r <= 1'b0;
    end else begin
      framing_error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= 16'd0;
          if (!rx_sync_r && rx_prev_r) begin
            state_r <= START;
          end
        end
        START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            state_r <= sample_s ? IDLE : DATA;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= 16'd0;
            shift_r <= {sample_s, shift_r[7:1]};
            if (idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        STOP: begin
          // Return to IDLE mid stop bit so an immediately following start edge is caught
          if (cnt_r == BIT_LAST) begin
            cnt_r           <= 16'd0;
            state_r         <= IDLE;
            framing_error_r <= ~sample_s;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 16'd0;
        end
      endcase
    end
  end

  assign stop_hit_s = (state_r == STOP) && (cnt_r == BIT_LAST);
  assign push_s     = stop_hit_s & sample_s;
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s      = data_read & ~empty_s;
  // A pop on a full FIFO frees the slot the push lands in
  assign accept_s   = push_s & (~full_s | pop_s);

  // FIFO pointers and overflow pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= push_s & full_s & ~pop_s;
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // FIFO storage, written only for accepted bytes
  always_ff @(posedge clk) begin
    if (rst_n && accept_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
    end
  end

  assign data_valid    = ~empty_s;
  assign data          = empty_s ? 8'h00 : mem_r[rd_ptr_r[AW-1:0]];
  assign framing_error = framing_error_r;
  assign overflow      = overflow_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at default parameters (192 clk/bit).
module tb_uart_receiver;

  localparam int CPB   = 48000000 / 250000;
  localparam int FRAME = 10 * CPB;
  // Stimulus cycle index of the stop-sample edge: 3 cycles sync/detect, half bit, 9 bits
  localparam int SE    = 3 + CPB / 2 + 9 * CPB;
  localparam int GLITCH_C = CPB / 2 + 3 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       data_read;
  logic       framing_error;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  always #5 clk = ~clk;

  uart_receiver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .data         (data),
    .data_valid   (data_valid),
    .data_read    (data_read),
    .framing_error(framing_error),
    .overflow     (overflow)
  );

  always @(posedge clk) begin
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (overflow) ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives stimulus cycles [from,to) of one frame; cycle 'glitch' gets its level inverted
  task automatic send_part(input logic [7:0] b, input logic stop, input int from, input int to,
                           input int glitch);
    for (int c = from; c < to; c++) begin
      int s;
      s = c / CPB;
      if (s == 0) rx = 1'b0;
      else if (s <= 8) rx = b[s-1];
      else rx = stop;
      if (c == glitch) rx = ~rx;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_part(b, 1'b1, 0, FRAME, -1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop();
    data_read = 1'b1;
    @(posedge clk);
    #1;
    data_read = 1'b0;
  endtask

  initial begin
    rx        = 1'b1;
    data_read = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {7'd0, data_valid}, 8'h00);
    chk("reset_data", data, 8'h00);
    chk("reset_fe", {7'd0, framing_error}, 8'h00);
    chk("reset_ov", {7'd0, overflow}, 8'h00);
    rst_n = 1'b1;
    idle(5);

    // Single byte with exact push latency
    send_part(8'hA5, 1'b1, 0, SE - 1, -1);
    chk("a5_valid_before", {7'd0, data_valid}, 8'h00);
    send_part(8'hA5, 1'b1, SE - 1, SE, -1);
    chk("a5_valid", {7'd0, data_valid}, 8'h01);
    chk("a5_data", data, 8'hA5);
    send_part(8'hA5, 1'b1, SE, FRAME, -1);
    pop();
    chk("a5_empty_after_read", {7'd0, data_valid}, 8'h00);
    chk("a5_data_zero", data, 8'h00);

    // Short low pulse: rejected at the start-bit check
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(300);
    chk("glitch_no_push", {7'd0, data_valid}, 8'h00);
    chk("glitch_no_fe", 8'(fe_cnt), 8'h00);

    // Bad stop bit
    send_part(8'h3C, 1'b0, 0, SE, -1);
    chk("fe_pulse", {7'd0, framing_error}, 8'h01);
    chk("fe_no_push", {7'd0, data_valid}, 8'h00);
    send_part(8'h3C, 1'b0, SE, SE + 1, -1);
    chk("fe_one_cycle", {7'd0, framing_error}, 8'h00);
    send_part(8'h3C, 1'b0, SE + 1, FRAME, -1);
    idle(20);
    chk("fe_count", 8'(fe_cnt), 8'h01);
    chk("fe_fifo_empty", {7'd0, data_valid}, 8'h00);
    send(8'h7E);
    chk("after_fe_valid", {7'd0, data_valid}, 8'h01);
    chk("after_fe_data", data, 8'h7E);
    pop();
    chk("after_fe_empty", {7'd0, data_valid}, 8'h00);

    // 17 back-to-back bytes: the 17th overflows
    for (int i = 0; i < 16; i++) send(8'(i));
    chk("fill_head", data, 8'h00);
    chk("fill_no_ov", 8'(ov_cnt), 8'h00);
    send_part(8'h10, 1'b1, 0, SE, -1);
    chk("ov_pulse", {7'd0, overflow}, 8'h01);
    send_part(8'h10, 1'b1, SE, SE + 1, -1);
    chk("ov_one_cycle", {7'd0, overflow}, 8'h00);
    send_part(8'h10, 1'b1, SE + 1, FRAME, -1);
    chk("ov_count", 8'(ov_cnt), 8'h01);
    chk("ov_head_kept", data, 8'h00);

    // Full FIFO, pop on the push edge of 8'h55: accepted, no overflow
    send_part(8'h55, 1'b1, 0, SE - 1, -1);
    data_read = 1'b1;
    send_part(8'h55, 1'b1, SE - 1, SE, -1);
    data_read = 1'b0;
    chk("pushpop_no_ov", {7'd0, overflow}, 8'h00);
    chk("pushpop_valid", {7'd0, data_valid}, 8'h01);
    chk("pushpop_head", data, 8'h01);
    send_part(8'h55, 1'b1, SE, FRAME, -1);
    chk("pushpop_ov_count", 8'(ov_cnt), 8'h01);
    for (int i = 1; i < 16; i++) begin
      chk("drain_order", data, 8'(i));
      pop();
    end
    chk("drain_last_55", data, 8'h55);
    pop();
    chk("drain_empty", {7'd0, data_valid}, 8'h00);

    // Reset mid-frame with bytes queued
    send(8'h11);
    send(8'h22);
    send(8'h33);
    chk("queued_head", data, 8'h11);
    send_part(8'hF0, 1'b1, 0, 1000, -1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_valid", {7'd0, data_valid}, 8'h00);
    chk("rst_data", data, 8'h00);
    send_part(8'hF0, 1'b1, 1000, FRAME, -1);
    idle(20);
    chk("rst_no_push", {7'd0, data_valid}, 8'h00);
    send(8'hC3);
    chk("rst_next_valid", {7'd0, data_valid}, 8'h01);
    chk("rst_next_data", data, 8'hC3);
    pop();
    chk("rst_next_empty", {7'd0, data_valid}, 8'h00);
    chk("rst_fe_count", 8'(fe_cnt), 8'h01);
    chk("rst_ov_count", 8'(ov_cnt), 8'h01);

    // One-cycle high glitch on the bit-2 sample point of 8'h00
    send_part(8'h00, 1'b1, 0, FRAME, GLITCH_C);
    chk("vote_valid", {7'd0, data_valid}, 8'h01);
`ifdef UART_RX_MAJORITY_VOTE_EN
    chk("vote_data", data, 8'h00);
`else
    chk("vote_data", data, 8'h04);
`endif
    pop();
    chk("vote_empty", {7'd0, data_valid}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
